qbert_move_ctrl: RTL and testbench
==================================

// Module: qbert_move_ctrl
// PURPOSE
//  Qbert movement controller; sits directly upstream of the 6-cube pyramid map renderer.
//  Accepts diagonal move commands and tracks Qbert's cube (3 ranks, 6 cubes), lives and visited-cube mask.
//  Animates jumps/falls frame by frame; drives sprite anchor qbert_x/qbert_y, qbert_jump and the visited mask
//  (bit order {R1n1,R1n2,R1n3,R2n1,R2n2,R3n1}) that the map uses to colour top faces.
// PARAMETERS
//  XLENGTH      11'd55   cube face length (px), same as map
//  XDIAG_DEMI   11'd30   half x-diagonal (px), same as map
//  YDIAG_DEMI   10'd50   half y-diagonal (px), same as map
//  RANK1_X_OFFSET 11'd600 / RANK1_Y_OFFSET 10'd90  base-rank anchor, same as map
//  JUMP_LOG2    3        jump lasts 2**JUMP_LOG2 frames
//  FALL_FRAMES  16       frames spent falling off the pyramid
//  FALL_STEP    4        px per frame per axis while falling
// PORTS
//  clk         in  1   pixel clock
//  reset       in  1   asynchronous, active-low reset
//  frame_tick  in  1   1-cycle pulse per video frame
//  move_valid  in  1   move command strobe
//  move_dir    in  2   00=UL 01=UR 10=DL 11=DR
//  restart     in  1   synchronous game restart
//  move_ready  out 1   1 only in IDLE
//  qbert_x     out 11  sprite anchor x (cube offset)
//  qbert_y     out 10  sprite anchor y
//  qbert_jump  out 1   1 during JUMP and FALL
//  cube_idx    out 3   current cube: 5=R1n1 4=R1n2 3=R1n3 2=R2n1 1=R2n2 0=R3n1 (apex)
//  visited     out 6   visited[i] = cube i landed on
//  level_done  out 1   visited==6'h3F
//  lives       out 2   remaining lives
//  game_over   out 1   lives==0
// BEHAVIOUR
//  Cube anchors (x,y): R1n1(600,90) R1n2(600,191) R1n3(600,291) R2n1(514,140) R2n2(514,241) R3n1(429,190).
//    Formulas: R2x=R1x-XLENGTH-XDIAG_DEMI-1; R3x=R1x-2*XLENGTH-2*XDIAG_DEMI-1; n2 y=+2*YDIAG_DEMI+1; R1n3 y=R1y+4*YDIAG_DEMI+1.
//  Reset (reset=0, async) and restart=1 (sync, any state, highest priority): state IDLE, cube_idx=0, (qbert_x,qbert_y)=(429,190),
//    visited=6'b000001, lives=3, qbert_jump=0, level_done=0, game_over=0, move_ready=1. All outputs registered.
//  Lattice (rank r, pos n; rank r holds 4-r cubes): UL->(r+1,n-1) UR->(r+1,n) DL->(r-1,n) DR->(r-1,n+1).
//  FSM IDLE / JUMP / FALL / RESPAWN / DONE / OVER:
//   IDLE: move_valid accepted same cycle (move_ready=1). Valid target -> JUMP; off-pyramid target -> FALL. k=0, src=current anchor.
//   JUMP: on each frame_tick k++; pos = src + (((dst-src)*k) >>> JUMP_LOG2), signed 12-bit intermediates.
//     On tick with k==2**JUMP_LOG2: pos=dst exactly, cube_idx=target, visited|=1<<target, -> IDLE; if new visited==6'h3F -> DONE.
//   FALL: per frame_tick x += FALL_STEP (DL/DR) or -= (UL/UR); y -= FALL_STEP (UL/DL) or += (UR/DR); saturate at 0 and 2047/1023.
//     After FALL_FRAMES ticks -> RESPAWN.
//   RESPAWN (1 cycle): lives--, pos=(429,190), cube_idx=0, visited unchanged; lives becomes 0 -> OVER else IDLE.
//   DONE: level_done=1, frozen, move_ready=0. OVER: game_over=1, frozen, move_ready=0. Both exit only via restart/reset.
//  move_valid outside IDLE is dropped, never queued. move_valid coincident with frame_tick in IDLE: accept; that tick is not counted.
//  qbert_jump=1 exactly while in JUMP or FALL. reset mid-jump/fall returns immediately to reset values.
// TESTING
//  1 Reset release -> (429,190), cube_idx 0, visited 000001, lives 3, move_ready 1, qbert_jump 0.
//  2 IDLE, DL from apex + 8 ticks -> after tick 4 pos (471,165); after tick 8 (514,140), cube_idx 2, visited 000101, IDLE.
//  3 move_valid pulsed mid-JUMP -> ignored, move_ready 0, trajectory and landing unchanged.
//  4 Apex UL -> FALL; after 16 ticks pos (365,126), then RESPAWN: (429,190), lives 2, visited unchanged.
//  5 Three falls -> lives 0, game_over 1, move_ready 0; restart -> reset values.
//  6 From apex DL,DL,UR,DR,UR,DR -> visited 6'h3F, level_done 1, DONE, further moves ignored.

Source files
------------

// File: rtl/qbert_move_ctrl.sv
// Qbert movement controller: tracks cube, lives and visited mask on the 6-cube pyramid and
// animates jumps/falls once per video frame. All outputs are registered.
module qbert_move_ctrl #(
    parameter logic [10:0] XLENGTH        = 11'd55,
    parameter logic [10:0] XDIAG_DEMI     = 11'd30,
    parameter logic [9:0]  YDIAG_DEMI     = 10'd50,
    parameter logic [10:0] RANK1_X_OFFSET = 11'd600,
    parameter logic [9:0]  RANK1_Y_OFFSET = 10'd90,
    parameter int unsigned JUMP_LOG2      = 3,
    parameter int unsigned FALL_FRAMES    = 16,
    parameter int unsigned FALL_STEP      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    input  logic        restart,
    output logic        move_ready,
    output logic [10:0] qbert_x,
    output logic [9:0]  qbert_y,
    output logic        qbert_jump,
    output logic [2:0]  cube_idx,
    output logic [5:0]  visited,
    output logic        level_done,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [2:0] {StIdle, StJump, StFall, StRespawn, StDone, StOver} state_e;

    localparam logic [10:0] XR1 = RANK1_X_OFFSET;
    localparam logic [10:0] XR2 = RANK1_X_OFFSET - XLENGTH - XDIAG_DEMI - 11'd1;
    localparam logic [10:0] XR3 = RANK1_X_OFFSET - XLENGTH - XLENGTH - XDIAG_DEMI - XDIAG_DEMI
                                  - 11'd1;
    localparam logic [9:0]  YR1N1 = RANK1_Y_OFFSET;
    localparam logic [9:0]  YR1N2 = RANK1_Y_OFFSET + YDIAG_DEMI + YDIAG_DEMI + 10'd1;
    localparam logic [9:0]  YR1N3 = RANK1_Y_OFFSET + YDIAG_DEMI + YDIAG_DEMI + YDIAG_DEMI
                                    + YDIAG_DEMI + 10'd1;
    localparam logic [9:0]  YR2N1 = RANK1_Y_OFFSET + YDIAG_DEMI;
    localparam logic [9:0]  YR2N2 = YR2N1 + YDIAG_DEMI + YDIAG_DEMI + 10'd1;
    localparam logic [9:0]  YR3   = RANK1_Y_OFFSET + YDIAG_DEMI + YDIAG_DEMI;

    localparam logic [4:0]  JumpFrames = 5'(1 << JUMP_LOG2);
    localparam logic [4:0]  FallFrames = 5'(FALL_FRAMES);
    localparam logic [11:0] FallStep   = 12'(FALL_STEP);

    function automatic logic [10:0] anchor_x(input logic [2:0] idx);
        case (idx)
            3'd5, 3'd4, 3'd3: anchor_x = XR1;
            3'd2, 3'd1:       anchor_x = XR2;
            default:          anchor_x = XR3;
        endcase
    endfunction

    function automatic logic [9:0] anchor_y(input logic [2:0] idx);
        case (idx)
            3'd5:    anchor_y = YR1N1;
            3'd4:    anchor_y = YR1N2;
            3'd3:    anchor_y = YR1N3;
            3'd2:    anchor_y = YR2N1;
            3'd1:    anchor_y = YR2N2;
            default: anchor_y = YR3;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic [10:0] src_x_q, src_x_d, x_q, x_d;
    logic [9:0]  src_y_q, src_y_d, y_q, y_d;
    logic [2:0]  dst_q, dst_d, cube_q, cube_d;
    logic [1:0]  dir_q, dir_d, lives_q, lives_d;
    logic [5:0]  visited_q, visited_d;
    logic        ready_q, ready_d, jump_q, jump_d, done_q, done_d, over_q, over_d;

    // Lattice coordinates of the current cube and of the commanded target.
    logic [2:0]  cur_r, cur_n, tgt_r, tgt_n, tgt_idx;
    logic        tgt_valid;

    always_comb begin
        cur_r = 3'd3;
        cur_n = 3'd1;
        case (cube_q)
            3'd5: begin cur_r = 3'd1; cur_n = 3'd1; end
            3'd4: begin cur_r = 3'd1; cur_n = 3'd2; end
            3'd3: begin cur_r = 3'd1; cur_n = 3'd3; end
            3'd2: begin cur_r = 3'd2; cur_n = 3'd1; end
            3'd1: begin cur_r = 3'd2; cur_n = 3'd2; end
            default: ;
        endcase
        case (move_dir)
            2'b00:   begin tgt_r = cur_r + 3'd1; tgt_n = cur_n - 3'd1; end
            2'b01:   begin tgt_r = cur_r + 3'd1; tgt_n = cur_n;        end
            2'b10:   begin tgt_r = cur_r - 3'd1; tgt_n = cur_n;        end
            default: begin tgt_r = cur_r - 3'd1; tgt_n = cur_n + 3'd1; end
        endcase
        tgt_valid = 1'b1;
        tgt_idx   = 3'd0;
        case ({tgt_r, tgt_n})
            {3'd1, 3'd1}: tgt_idx = 3'd5;
            {3'd1, 3'd2}: tgt_idx = 3'd4;
            {3'd1, 3'd3}: tgt_idx = 3'd3;
            {3'd2, 3'd1}: tgt_idx = 3'd2;
            {3'd2, 3'd2}: tgt_idx = 3'd1;
            {3'd3, 3'd1}: tgt_idx = 3'd0;
            default:      tgt_valid = 1'b0;
        endcase
    end

    logic [4:0]         k_inc;
    logic signed [11:0] dx, dy, kk, px, py;
    logic [10:0]        interp_x, fall_x;
    logic [9:0]         interp_y, fall_y;
    logic [11:0]        fx_add, fy_add;

    always_comb begin
        k_inc    = k_q + 5'd1;
        kk       = signed'({7'd0, k_inc});
        dx       = signed'({1'b0, anchor_x(dst_q)} - {1'b0, src_x_q});
        dy       = signed'({2'b0, anchor_y(dst_q)} - {2'b0, src_y_q});
        px       = (dx * kk) >>> JUMP_LOG2;
        py       = (dy * kk) >>> JUMP_LOG2;
        interp_x = 11'({1'b0, src_x_q} + unsigned'(px));
        interp_y = 10'({2'b0, src_y_q} + unsigned'(py));

        // Falling moves away from the pyramid, clamped to the screen coordinate range.
        fx_add = {1'b0, x_q} + FallStep;
        fy_add = {2'b0, y_q} + FallStep;
        if (dir_q[1]) fall_x = (fx_add > 12'd2047) ? 11'h7FF : fx_add[10:0];
        else          fall_x = ({1'b0, x_q} < FallStep) ? 11'd0 : 11'({1'b0, x_q} - FallStep);
        if (dir_q[0]) fall_y = (fy_add > 12'd1023) ? 10'h3FF : fy_add[9:0];
        else          fall_y = ({2'b0, y_q} < FallStep) ? 10'd0 : 10'({2'b0, y_q} - FallStep);
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        src_x_d   = src_x_q;
        src_y_d   = src_y_q;
        dst_d     = dst_q;
        dir_d     = dir_q;
        x_d       = x_q;
        y_d       = y_q;
        cube_d    = cube_q;
        visited_d = visited_q;
        lives_d   = lives_q;

        if (restart) begin
            state_d   = StIdle;
            k_d       = 5'd0;
            x_d       = XR3;
            y_d       = YR3;
            cube_d    = 3'd0;
            visited_d = 6'b000001;
            lives_d   = 2'd3;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (move_valid) begin
                        dir_d   = move_dir;
                        k_d     = 5'd0;
                        src_x_d = x_q;
                        src_y_d = y_q;
                        dst_d   = tgt_idx;
                        state_d = tgt_valid ? StJump : StFall;
                    end
                end
                StJump: begin
                    if (frame_tick) begin
                        if (k_inc == JumpFrames) begin
                            x_d       = anchor_x(dst_q);
                            y_d       = anchor_y(dst_q);
                            cube_d    = dst_q;
                            visited_d = visited_q | (6'b000001 << dst_q);
                            state_d   = (visited_d == 6'h3F) ? StDone : StIdle;
                        end else begin
                            k_d = k_inc;
                            x_d = interp_x;
                            y_d = interp_y;
                        end
                    end
                end
                StFall: begin
                    if (frame_tick) begin
                        x_d = fall_x;
                        y_d = fall_y;
                        k_d = k_inc;
                        if (k_inc == FallFrames) state_d = StRespawn;
                    end
                end
                StRespawn: begin
                    lives_d = lives_q - 2'd1;
                    x_d     = XR3;
                    y_d     = YR3;
                    cube_d  = 3'd0;
                    state_d = (lives_q == 2'd1) ? StOver : StIdle;
                end
                default: ;
            endcase
        end

        ready_d = (state_d == StIdle);
        jump_d  = (state_d == StJump) || (state_d == StFall);
        done_d  = (state_d == StDone);
        over_d  = (state_d == StOver);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            k_q       <= 5'd0;
            src_x_q   <= XR3;
            src_y_q   <= YR3;
            dst_q     <= 3'd0;
            dir_q     <= 2'b00;
            x_q       <= XR3;
            y_q       <= YR3;
            cube_q    <= 3'd0;
            visited_q <= 6'b000001;
            lives_q   <= 2'd3;
            ready_q   <= 1'b1;
            jump_q    <= 1'b0;
            done_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            src_x_q   <= src_x_d;
            src_y_q   <= src_y_d;
            dst_q     <= dst_d;
            dir_q     <= dir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cube_q    <= cube_d;
            visited_q <= visited_d;
            lives_q   <= lives_d;
            ready_q   <= ready_d;
            jump_q    <= jump_d;
            done_q    <= done_d;
            over_q    <= over_d;
        end
    end

    assign move_ready = ready_q;
    assign qbert_x    = x_q;
    assign qbert_y    = y_q;
    assign qbert_jump = jump_q;
    assign cube_idx   = cube_q;
    assign visited    = visited_q;
    assign level_done = done_q;
    assign lives      = lives_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Directed bench for qbert_move_ctrl: a table of single-cycle vectors for a full jump round trip,
// then hand-written sequences for falls, game over, level completion and mid-move resets.
module tb_qbert_move_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick, move_valid, restart;
    logic [1:0]  move_dir;
    logic        move_ready, qbert_jump, level_done, game_over;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;
    logic [2:0]  cube_idx;
    logic [5:0]  visited;
    logic [1:0]  lives;

    int n_checks = 0;
    int n_pass   = 0;

    qbert_move_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .restart    (restart),
        .move_ready (move_ready),
        .qbert_x    (qbert_x),
        .qbert_y    (qbert_y),
        .qbert_jump (qbert_jump),
        .cube_idx   (cube_idx),
        .visited    (visited),
        .level_done (level_done),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        t;
        logic        v;
        logic [1:0]  d;
        logic [10:0] x;
        logic [9:0]  y;
        logic [2:0]  c;
        logic [5:0]  vis;
        logic        r;
        logic        j;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [10:0] ex, input logic [9:0] ey,
                       input logic [2:0] ec, input logic [5:0] ev, input logic [1:0] el,
                       input logic er, input logic ej, input logic ed, input logic eo);
        n_checks++;
        if (qbert_x === ex && qbert_y === ey && cube_idx === ec && visited === ev &&
            lives === el && move_ready === er && qbert_jump === ej && level_done === ed &&
            game_over === eo) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got x=%0d y=%0d cube=%0d vis=%b lives=%0d rdy=%b jmp=%b done=%b over=%b; want x=%0d y=%0d cube=%0d vis=%b lives=%0d rdy=%b jmp=%b done=%b over=%b",
                     nm, qbert_x, qbert_y, cube_idx, visited, lives, move_ready, qbert_jump,
                     level_done, game_over, ex, ey, ec, ev, el, er, ej, ed, eo);
        end
    endtask

    // One clock with the given strobes; outputs are stable 1ns after the edge.
    task automatic cyc(input logic t, input logic v, input logic [1:0] d);
        frame_tick = t;
        move_valid = v;
        move_dir   = d;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        move_valid = 1'b0;
    endtask

    task automatic jump_to(input logic [1:0] d);
        cyc(1'b0, 1'b1, d);
        repeat (8) cyc(1'b1, 1'b0, 2'b00);
    endtask

    task automatic fall(input logic [1:0] d);
        cyc(1'b0, 1'b1, d);
        repeat (16) cyc(1'b1, 1'b0, 2'b00);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        // DL from apex to R2n1 (with ignored strobes mid-jump), then UR back to the apex.
        tbl[0]  = '{1'b0, 1'b1, 2'b10, 11'd429, 10'd190, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 11'd439, 10'd183, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 11'd439, 10'd183, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 2'b00, 11'd450, 10'd177, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 2'b00, 11'd450, 10'd177, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 11'd460, 10'd171, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 2'b11, 11'd471, 10'd165, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'b00, 11'd482, 10'd158, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 11'd492, 10'd152, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'b00, 11'd503, 10'd146, 3'd0, 6'b000001, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 11'd514, 10'd140, 3'd2, 6'b000101, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 2'b01, 11'd514, 10'd140, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 2'b00, 11'd503, 10'd146, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 2'b00, 11'd492, 10'd152, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 2'b00, 11'd482, 10'd158, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 2'b00, 11'd471, 10'd165, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 2'b00, 11'd460, 10'd171, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 2'b00, 11'd450, 10'd177, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 2'b00, 11'd439, 10'd183, 3'd2, 6'b000101, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 2'b00, 11'd429, 10'd190, 3'd0, 6'b000101, 1'b1, 1'b0};

        reset      = 1'b0;
        frame_tick = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'b00;
        restart    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 1'b0, 2'b00);
        chk("reset", 11'd429, 10'd190, 3'd0, 6'b000001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].t, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].vis, 2'd3,
                tbl[i].r, tbl[i].j, 1'b0, 1'b0);
        end

        // First fall: UL off the apex.
        cyc(1'b0, 1'b1, 2'b00);
        chk("fall_start", 11'd429, 10'd190, 3'd0, 6'b000101, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (15) cyc(1'b1, 1'b0, 2'b00);
        chk("fall_15", 11'd369, 10'd130, 3'd0, 6'b000101, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 2'b10);
        chk("fall_16", 11'd365, 10'd126, 3'd0, 6'b000101, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00);
        chk("respawn1", 11'd429, 10'd190, 3'd0, 6'b000101, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Second fall: UR off the apex.
        fall(2'b01);
        chk("fall2_end", 11'd365, 10'd254, 3'd0, 6'b000101, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00);
        chk("respawn2", 11'd429, 10'd190, 3'd0, 6'b000101, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        fall(2'b00);
        cyc(1'b0, 1'b0, 2'b00);
        chk("game_over", 11'd429, 10'd190, 3'd0, 6'b000101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'b10);
        cyc(1'b1, 1'b0, 2'b00);
        chk("over_frozen", 11'd429, 10'd190, 3'd0, 6'b000101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_restart();
        chk("restart_over", 11'd429, 10'd190, 3'd0, 6'b000001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Full level tour.
        jump_to(2'b10);
        jump_to(2'b10);
        chk("tour2", 11'd600, 10'd90, 3'd5, 6'b100101, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        jump_to(2'b01);
        jump_to(2'b11);
        jump_to(2'b01);
        chk("tour5", 11'd514, 10'd241, 3'd1, 6'b110111, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        jump_to(2'b11);
        chk("level_done", 11'd600, 10'd291, 3'd3, 6'h3F, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b00);
        repeat (3) cyc(1'b1, 1'b0, 2'b00);
        chk("done_frozen", 11'd600, 10'd291, 3'd3, 6'h3F, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        do_restart();
        chk("restart_done", 11'd429, 10'd190, 3'd0, 6'b000001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Restart during a fall.
        cyc(1'b0, 1'b1, 2'b00);
        repeat (3) cyc(1'b1, 1'b0, 2'b00);
        chk("fall_3", 11'd417, 10'd178, 3'd0, 6'b000001, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        do_restart();
        chk("restart_fall", 11'd429, 10'd190, 3'd0, 6'b000001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during a jump.
        jump_to(2'b10);
        cyc(1'b0, 1'b1, 2'b11);
        repeat (2) cyc(1'b1, 1'b0, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 11'd429, 10'd190, 3'd0, 6'b000001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
